// File: rtl/gpio_in_capture.sv
// GPIO input capture: synchronizes pins, queues masked-change snapshots in a FIFO drained via the register port.
// Define GPIO_CAP_SYNC2_EN for a two-flop synchronizer; otherwise a single flop is used.
module gpio_in_capture #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio,
    input  logic             sel,
    input  logic             wen,
    input  logic             ren,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             rvalid,
    output logic             irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef GPIO_CAP_SYNC2_EN
    localparam int unsigned SYNC_STAGES = 2;
`else
    localparam int unsigned SYNC_STAGES = 1;
`endif
    localparam logic [1:0] PRIME_CYCLES = 2'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] pins;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] chg;
    logic [1:0]       prime_cnt;
    logic             primed;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             empty;
    logic             full;

    logic             rd_en;
    logic             wr_en;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             ovf_set;
    logic             ovf_clr;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] rd_data;

`ifdef GPIO_CAP_SYNC2_EN
    logic [WIDTH-1:0] sync1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            pins  <= '0;
        end else begin
            sync1 <= gpio;
            pins  <= sync1;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pins <= '0;
        else       pins <= gpio;
    end
`endif

    // Priming holds off pushes until prev has caught up with the first real sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            prime_cnt <= '0;
        end else begin
            prev <= pins;
            if (!primed) prime_cnt <= prime_cnt + 2'd1;
        end
    end

    assign primed   = (prime_cnt == PRIME_CYCLES);
    assign chg      = (pins ^ prev) & mask;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign irq      = !empty;

    assign rd_en    = sel & ren & ~wen;
    assign wr_en    = sel & wen;
    assign pop      = rd_en && (addr == 2'd0) && !empty;
    assign push_req = (|chg) && primed;
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = wr_en && (addr == 2'd1) && datain[2];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pins;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            mask     <= '1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Set has priority over a same-cycle clear.
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (wr_en && addr == 2'd3) mask <= datain;
        end
    end

    always_comb begin
        status         = '0;
        status[0]      = empty;
        status[1]      = full;
        status[2]      = overflow;
        status[8 +: CW] = count;
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0:    rd_data = empty ? '0 : mem[rd_ptr];
            2'd1:    rd_data = status;
            2'd2:    rd_data = pins;
            default: rd_data = mask;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataout <= '0;
            rvalid  <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) dataout <= rd_data;
        end
    end

endmodule
